sdc_wb_regbank: RTL
===================

# sdc_wb_regbank

Parametrised WISHBONE register bank for the SD card controller, successor to the fixed-width register slave. It honours byte selects, flags unmapped and busy-blocked accesses with `wb_err_o`, and latches command/data interrupt events internally (sticky, write-one-to-clear) to drive interrupt lines. It sits between the system WISHBONE bus and the SD command/data engines.

## Interface
- `ADDR_W`, 8: WISHBONE address width (byte address).
- `BLKSIZE_W`, 12: block size register width.
- `BLKCNT_W`, 16: block count register width.
- `NUM_CMD_INT`, 5: number of command interrupt sources.
- `NUM_DATA_INT`, 3: number of data interrupt sources.
- `RESET_BLOCK_SIZE`, 512: reset value of `block_size_o`.
- `RESET_CLK_DIV`, 0: reset value of `clock_divider_o`.
- `wb_clk_i` in 1: the single clock; everything is synchronous to its rising edge.
- `wb_rst_i` in 1: asynchronous reset, active high.
- `wb_adr_i` in ADDR_W, `wb_dat_i` in 32, `wb_sel_i` in 4, `wb_we_i`/`wb_cyc_i`/`wb_stb_i` in 1: WISHBONE slave inputs.
- `wb_dat_o` out 32, `wb_ack_o` out 1, `wb_err_o` out 1: WISHBONE slave outputs.
- `cmd_busy_i`, `data_busy_i` in 1: engine busy flags.
- `cmd_int_set_i` in NUM_CMD_INT, `data_int_set_i` in NUM_DATA_INT: one-cycle event pulses.
- `response_i` in 128: the four response words; word k is bits [32k+31:32k].
- `argument_o` out 32, `command_o` out 14, `software_reset_o` out 1, `timeout_o` out 16, `controll_setting_o` out 16, `clock_divider_o` out 8, `block_size_o` out BLKSIZE_W, `block_count_o` out BLKCNT_W, `dma_addr_o` out 32: configuration registers.
- `cmd_start_o`, `data_start_rx_o`, `data_start_tx_o` out 1: one-cycle start pulses.
- `int_cmd_o`, `int_data_o` out 1: registered interrupt outputs.

## Operation
- Register map (byte addresses):
  - 0x00 argument (RW)
  - 0x04 command (RW)
  - 0x08 to 0x14 response 0 to 3 (RO)
  - 0x1C controller (RW)
  - 0x20 timeout (RW)
  - 0x24 clock divider (RW)
  - 0x28 reset (RW)
  - 0x2C voltage (RO, 0x0F)
  - 0x30 capabilities (RO, 0)
  - 0x34 cmd ISR (R, W1C)
  - 0x38 cmd ISER (RW)
  - 0x3C data ISR (R, W1C)
  - 0x40 data ISER (RW)
  - 0x44 block size (RW)
  - 0x48 block count (RW)
  - 0x60 dst addr (RW, starts RX)
  - 0x80 src addr (RW, starts TX)
- Unmapped address rule: any address with `wb_adr_i[1:0]` not equal to 0, or not in the map, is unmapped.
- Writes to read-only addresses are ignored and acknowledged.
- Byte lanes: bits [8k+7:8k] of a register update only if `wb_sel_i[k]`. W1C clears only bits in selected lanes.
- Unused and unimplemented bits read 0. Write data is truncated to the register width.
- Start pulses fire on an accepted write with `wb_sel_i` not equal to 0:
  - argument write fires `cmd_start_o`.
  - 0x60 write fires `data_start_rx_o`.
  - 0x80 write fires `data_start_tx_o`.
  - 0x60 and 0x80 share `dma_addr_o`; a read of either returns it.
- Busy lock:
  - A write to 0x00 or 0x04 while `cmd_busy_i` is high is blocked.
  - A write to 0x60, 0x80 or 0x48 while `data_busy_i` is high is blocked.
  - A blocked write is answered with `wb_err_o` instead of `wb_ack_o`, leaves the register unchanged and fires no pulse.
  - Reads are never blocked.
- Unmapped read or write: `wb_err_o`, no state change, `wb_dat_o` = 0.
- Interrupts:
  - Status bit i is set by `*_int_set_i[i]` and cleared by a W1C of 1.
  - If set and clear occur in the same cycle, set wins.
  - `software_reset_o`=1 holds both status registers at 0.
  - `int_cmd_o` is registered |(cmd status & cmd ISER); `int_data_o` is the same for the data registers.

## Timing
- Request at edge N: `wb_cyc_i & wb_stb_i` high, and neither `wb_ack_o` nor `wb_err_o` is high.
- Response at N+1: exactly one of ack/err goes high for one cycle.
  - `wb_dat_o` is valid in the same cycle as the response.
  - Register writes and start pulses take effect at N+1.
- A request held high through its response is not re-served in the response cycle. Back-to-back requests therefore get a response every second cycle.
- Busy flags are sampled at edge N only.
- Status set at edge N appears in the status register at N+1; the interrupt output follows at N+2.
- Reset (asynchronous, any time, including mid-transfer):
  - ack, err and all pulses go to 0 immediately.
  - `block_size_o` = RESET_BLOCK_SIZE, `clock_divider_o` = RESET_CLK_DIV.
  - All other outputs, including `dma_addr_o` and `wb_dat_o`, = 0.
  - An interrupted access is lost; the master retries.

## Test plan
- Reset, then read 0x44, 0x24, 0x2C: ack at N+1 with 0x200, RESET_CLK_DIV and 0x0F; all pulses, `int_*_o` and `dma_addr_o` are 0.
- Write 0x12345678 to 0x00 with sel=4'b0101: `argument_o`=0x00340078; `cmd_start_o` high exactly at N+1; read-back matches.
- Write 0x60 while `data_busy_i`=1: `wb_err_o` at N+1, no ack, no `data_start_rx_o`, `dma_addr_o` unchanged. Repeat with busy=0: ack plus one pulse.
- Pulse `cmd_int_set_i`=5'b00101 with ISER=5'b00100: status=5'b00101 and `int_cmd_o`=1 at N+2.
  - W1C of 0x4 issued in the same cycle as a new set of bit 2: bit 2 stays set.
  - W1C of 0x5 with no concurrent set: status=0 and `int_cmd_o`=0.
- Read 0x4C and 0x02: `wb_err_o`, `wb_dat_o`=0. Back-to-back held-stb reads of 0x08: responses every second cycle, data = `response_i[31:0]`.
- Assert `wb_rst_i` during an ack cycle: ack drops without waiting for a clock edge; all registers return to their reset values.

Source files
------------

// File: rtl/sdc_wb_regbank.sv
// WISHBONE register bank for the SD card controller: byte-lane writes, error responses
// for unmapped or busy-blocked accesses, sticky W1C interrupt status and start pulses.
module sdc_wb_regbank #(
  parameter int ADDR_W           = 8,
  parameter int BLKSIZE_W        = 12,
  parameter int BLKCNT_W         = 16,
  parameter int NUM_CMD_INT      = 5,
  parameter int NUM_DATA_INT     = 3,
  parameter int RESET_BLOCK_SIZE = 512,
  parameter int RESET_CLK_DIV    = 0
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [ADDR_W-1:0]       wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  input  logic [3:0]              wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  input  logic                    cmd_busy_i,
  input  logic                    data_busy_i,
  input  logic [NUM_CMD_INT-1:0]  cmd_int_set_i,
  input  logic [NUM_DATA_INT-1:0] data_int_set_i,
  input  logic [127:0]            response_i,
  output logic [31:0]             argument_o,
  output logic [13:0]             command_o,
  output logic                    software_reset_o,
  output logic [15:0]             timeout_o,
  output logic [15:0]             controll_setting_o,
  output logic [7:0]              clock_divider_o,
  output logic [BLKSIZE_W-1:0]    block_size_o,
  output logic [BLKCNT_W-1:0]     block_count_o,
  output logic [31:0]             dma_addr_o,
  output logic                    cmd_start_o,
  output logic                    data_start_rx_o,
  output logic                    data_start_tx_o,
  output logic                    int_cmd_o,
  output logic                    int_data_o
);

  typedef enum logic [4:0] {
    R_NONE, R_ARG, R_CMD, R_RSP0, R_RSP1, R_RSP2, R_RSP3, R_CTRL, R_TMO, R_CDIV, R_RST,
    R_VOLT, R_CAPS, R_CISR, R_CISER, R_DISR, R_DISER, R_BSIZE, R_BCNT, R_DST, R_SRC
  } reg_e;

  logic [31:0]             r_argument, r_dma, r_dat;
  logic [13:0]             r_command;
  logic [15:0]             r_controll, r_timeout;
  logic [7:0]              r_clk_div;
  logic                    r_sw_reset, r_ack, r_err;
  logic                    r_cmd_start, r_rx_start, r_tx_start, r_int_cmd, r_int_data;
  logic [BLKSIZE_W-1:0]    r_blk_size;
  logic [BLKCNT_W-1:0]     r_blk_cnt;
  logic [NUM_CMD_INT-1:0]  r_cmd_isr, r_cmd_iser, w_cmd_clr;
  logic [NUM_DATA_INT-1:0] r_data_isr, r_data_iser, w_data_clr;

  reg_e        w_reg;
  logic [31:0] w_adr, w_rdata, w_mask, w_wdat;
  logic        w_req, w_busy_block, w_fault, w_wr, w_any_sel;

  assign w_adr = 32'(wb_adr_i);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_reg = R_NONE;
    if (w_adr[1:0] == 2'b00) begin
      case (w_adr)
        32'h00:  w_reg = R_ARG;
        32'h04:  w_reg = R_CMD;
        32'h08:  w_reg = R_RSP0;
        32'h0C:  w_reg = R_RSP1;
        32'h10:  w_reg = R_RSP2;
        32'h14:  w_reg = R_RSP3;
        32'h1C:  w_reg = R_CTRL;
        32'h20:  w_reg = R_TMO;
        32'h24:  w_reg = R_CDIV;
        32'h28:  w_reg = R_RST;
        32'h2C:  w_reg = R_VOLT;
        32'h30:  w_reg = R_CAPS;
        32'h34:  w_reg = R_CISR;
        32'h38:  w_reg = R_CISER;
        32'h3C:  w_reg = R_DISR;
        32'h40:  w_reg = R_DISER;
        32'h44:  w_reg = R_BSIZE;
        32'h48:  w_reg = R_BCNT;
        32'h60:  w_reg = R_DST;
        32'h80:  w_reg = R_SRC;
        default: w_reg = R_NONE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      R_ARG:          w_rdata = r_argument;
      R_CMD:          w_rdata = 32'(r_command);
      R_RSP0:         w_rdata = response_i[31:0];
      R_RSP1:         w_rdata = response_i[63:32];
      R_RSP2:         w_rdata = response_i[95:64];
      R_RSP3:         w_rdata = response_i[127:96];
      R_CTRL:         w_rdata = 32'(r_controll);
      R_TMO:          w_rdata = 32'(r_timeout);
      R_CDIV:         w_rdata = 32'(r_clk_div);
      R_RST:          w_rdata = 32'(r_sw_reset);
      R_VOLT:         w_rdata = 32'h0000_000F;
      R_CISR:         w_rdata = 32'(r_cmd_isr);
      R_CISER:        w_rdata = 32'(r_cmd_iser);
      R_DISR:         w_rdata = 32'(r_data_isr);
      R_DISER:        w_rdata = 32'(r_data_iser);
      R_BSIZE:        w_rdata = 32'(r_blk_size);
      R_BCNT:         w_rdata = 32'(r_blk_cnt);
      R_DST, R_SRC:   w_rdata = r_dma;
      default:        w_rdata = '0;
    endcase
  end

  // Merge against the current (zero-extended) value so unselected lanes keep their contents.
  assign w_mask    = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_wdat    = (w_rdata & ~w_mask) | (wb_dat_i & w_mask);
  assign w_any_sel = |wb_sel_i;

  assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
  assign w_busy_block = wb_we_i & ((cmd_busy_i & (w_reg inside {R_ARG, R_CMD})) |
                                   (data_busy_i & (w_reg inside {R_DST, R_SRC, R_BCNT})));
  assign w_fault      = (w_reg == R_NONE) | w_busy_block;
  assign w_wr         = w_req & wb_we_i & ~w_fault;

  assign w_cmd_clr  = (w_wr && w_reg == R_CISR) ?
                      (wb_dat_i[NUM_CMD_INT-1:0] & w_mask[NUM_CMD_INT-1:0]) : '0;
  assign w_data_clr = (w_wr && w_reg == R_DISR) ?
                      (wb_dat_i[NUM_DATA_INT-1:0] & w_mask[NUM_DATA_INT-1:0]) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_dat       <= '0;
      r_argument  <= '0;
      r_command   <= '0;
      r_controll  <= '0;
      r_timeout   <= '0;
      r_clk_div   <= 8'(RESET_CLK_DIV);
      r_sw_reset  <= 1'b0;
      r_blk_size  <= BLKSIZE_W'(RESET_BLOCK_SIZE);
      r_blk_cnt   <= '0;
      r_dma       <= '0;
      r_cmd_iser  <= '0;
      r_data_iser <= '0;
      r_cmd_isr   <= '0;
      r_data_isr  <= '0;
      r_cmd_start <= 1'b0;
      r_rx_start  <= 1'b0;
      r_tx_start  <= 1'b0;
      r_int_cmd   <= 1'b0;
      r_int_data  <= 1'b0;
    end else begin
      r_ack       <= w_req & ~w_fault;
      r_err       <= w_req & w_fault;
      r_dat       <= (w_req & ~w_fault) ? w_rdata : '0;
      r_cmd_start <= w_wr & w_any_sel & (w_reg == R_ARG);
      r_rx_start  <= w_wr & w_any_sel & (w_reg == R_DST);
      r_tx_start  <= w_wr & w_any_sel & (w_reg == R_SRC);
      if (w_wr) begin
        case (w_reg)
          R_ARG:        r_argument  <= w_wdat;
          R_CMD:        r_command   <= w_wdat[13:0];
          R_CTRL:       r_controll  <= w_wdat[15:0];
          R_TMO:        r_timeout   <= w_wdat[15:0];
          R_CDIV:       r_clk_div   <= w_wdat[7:0];
          R_RST:        r_sw_reset  <= w_wdat[0];
          R_CISER:      r_cmd_iser  <= w_wdat[NUM_CMD_INT-1:0];
          R_DISER:      r_data_iser <= w_wdat[NUM_DATA_INT-1:0];
          R_BSIZE:      r_blk_size  <= w_wdat[BLKSIZE_W-1:0];
          R_BCNT:       r_blk_cnt   <= w_wdat[BLKCNT_W-1:0];
          R_DST, R_SRC: r_dma       <= w_wdat;
          default:      ;
        endcase
      end
      // Set wins over a same-cycle clear; software reset pins both status registers low.
      r_cmd_isr  <= r_sw_reset ? '0 : ((r_cmd_isr & ~w_cmd_clr) | cmd_int_set_i);
      r_data_isr <= r_sw_reset ? '0 : ((r_data_isr & ~w_data_clr) | data_int_set_i);
      r_int_cmd  <= |(r_cmd_isr & r_cmd_iser);
      r_int_data <= |(r_data_isr & r_data_iser);
    end
  end

  assign wb_dat_o           = r_dat;
  assign wb_ack_o           = r_ack;
  assign wb_err_o           = r_err;
  assign argument_o         = r_argument;
  assign command_o          = r_command;
  assign software_reset_o   = r_sw_reset;
  assign timeout_o          = r_timeout;
  assign controll_setting_o = r_controll;
  assign clock_divider_o    = r_clk_div;
  assign block_size_o       = r_blk_size;
  assign block_count_o      = r_blk_cnt;
  assign dma_addr_o         = r_dma;
  assign cmd_start_o        = r_cmd_start;
  assign data_start_rx_o    = r_rx_start;
  assign data_start_tx_o    = r_tx_start;
  assign int_cmd_o          = r_int_cmd;
  assign int_data_o         = r_int_data;

endmodule
